// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared widths, reset value and count type for counter_practice
package counter_pkg;

  localparam int unsigned COUNTER_WIDTH     = 4;
  localparam int unsigned COUNTER_RESET_VAL = 0;

  typedef logic [COUNTER_WIDTH-1:0] count_t;

endpackage : counter_pkg

// File: rtl/counter_practice.sv
// rtl/counter_practice.sv - free-running modulo-2**WIDTH up-counter, synchronous reset
// rst_n keeps its legacy name but is active-high: the counter reloads while rst_n = 1.
module counter_practice
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = COUNTER_WIDTH,
  parameter int unsigned RESET_VAL = COUNTER_RESET_VAL,
  parameter int unsigned STEP      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

  if (RESET_VAL >= (2 ** WIDTH)) begin : g_bad_reset_val
    $error("counter_practice: RESET_VAL does not fit in WIDTH bits");
  end
  if (STEP >= (2 ** WIDTH)) begin : g_bad_step
    $error("counter_practice: STEP must be below 2**WIDTH");
  end

  logic [WIDTH-1:0] r_cnt;

  // Truncating add gives the wrap with no flag or stall.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_cnt <= RESET_W;
    end else begin
      r_cnt <= r_cnt + STEP_W;
    end
  end

  assign out = r_cnt;

  a_reset_load : assert property (@(posedge clk) rst_n |=> (out == RESET_W));

  a_step : assert property (@(posedge clk)
    (!rst_n && !$isunknown(out)) |=> (out == WIDTH'($past(out) + STEP_W)));

endmodule : counter_practice

// File: tb/tb_counter_practice.sv
// tb/tb_counter_practice.sv - scoreboard bench for default and WIDTH=3/STEP=3 counters
module tb_counter_practice;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rst3 = 1'b1;
  logic [3:0] out;
  logic [2:0] out3;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_cnt = 4'd0;
  logic [2:0] exp_cnt3 = 3'd0;
  logic [3:0] q_cnt[$];
  logic [2:0] q_cnt3[$];

  always #5 clk = ~clk;

  counter_practice u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (out)
  );

  counter_practice #(.WIDTH(3), .RESET_VAL(0), .STEP(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst3),
    .out   (out3)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, expv, $time);
    end
  endtask

  // Drive reset on the falling edge, predict, then compare just after the rising edge.
  task automatic tick(input logic r, input logic r3, input bit glitch);
    @(negedge clk);
    rst_n = r;
    rst3  = r3;
    exp_cnt  = r  ? 4'd0 : 4'(exp_cnt + 4'd1);
    exp_cnt3 = r3 ? 3'd0 : 3'(exp_cnt3 + 3'd3);
    q_cnt.push_back(exp_cnt);
    q_cnt3.push_back(exp_cnt3);
    if (glitch) begin
      #2 rst_n = 1'b1;
      #2 rst_n = 1'b0;
    end
    @(posedge clk);
    #1;
    check_val("cnt", 32'(out), 32'(q_cnt.pop_front()));
    check_val("cnt_w3s3", 32'(out3), 32'(q_cnt3.pop_front()));
  endtask

  initial begin
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b1, 1'b0);
    check_val("after_release_5", 32'(out), 32'd5);

    tick(1'b1, 1'b1, 1'b0);
    repeat (16) tick(1'b0, 1'b1, 1'b0);
    check_val("wrap_to_zero", 32'(out), 32'd0);
    tick(1'b0, 1'b1, 1'b0);
    check_val("after_wrap", 32'(out), 32'd1);

    repeat (8) tick(1'b0, 1'b1, 1'b0);
    check_val("reach_nine", 32'(out), 32'd9);
    tick(1'b1, 1'b1, 1'b0);
    check_val("mid_reset", 32'(out), 32'd0);
    tick(1'b0, 1'b1, 1'b0);
    check_val("after_pulse", 32'(out), 32'd1);

    tick(1'b0, 1'b1, 1'b1);
    check_val("glitch_ignored", 32'(out), 32'd2);
    tick(1'b0, 1'b1, 1'b0);

    repeat (6) tick(1'b0, 1'b0, 1'b0);
    check_val("w3s3_last", 32'(out3), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_counter_practice
